// File: rtl/hilo_mc_ctrl.sv
// hilo_mc_ctrl: execute-stage sequencer for multi-cycle HI/LO operations.
// MADD/MADDU/MSUB/MSUBU take two cycles (accumulate, then write back).
// DIV/DIVU hand the operands to an external iterative divider and wait
// for its ready pulse before writing {remainder,quotient} to HI/LO.
// A flush (annul_i) abandons whatever is in flight.
//
// state      | meaning
// -----------+------------------------------------------------------------
// S_IDLE     | no multi-cycle op in flight; decode aluop_i each cycle
// S_MACC     | signed/negated product latched, write hilo_temp + hilo_i
// S_DIV_WAIT | divider started, stall EX until div_ready_i
// S_DIV_DONE | divider result latched in hilo_temp, write it back

module hilo_mc_ctrl #(
  parameter int              OP_W     = 8,
  parameter logic [OP_W-1:0] OP_MADD  = 8'b10100110,
  parameter logic [OP_W-1:0] OP_MADDU = 8'b10101000,
  parameter logic [OP_W-1:0] OP_MSUB  = 8'b10101010,
  parameter logic [OP_W-1:0] OP_MSUBU = 8'b10101011,
  parameter logic [OP_W-1:0] OP_DIV   = 8'b00011010,
  parameter logic [OP_W-1:0] OP_DIVU  = 8'b00011011
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [OP_W-1:0] aluop_i,
  input  logic [31:0]     reg1_i,
  input  logic [31:0]     reg2_i,
  input  logic [63:0]     mul_i,
  input  logic [63:0]     hilo_i,
  input  logic            annul_i,
  input  logic [63:0]     div_result_i,
  input  logic            div_ready_i,
  output logic            stallreq_o,
  output logic            whilo_o,
  output logic [63:0]     hilo_o,
  output logic            div_start_o,
  output logic            div_signed_o,
  output logic [31:0]     div_opdata1_o,
  output logic [31:0]     div_opdata2_o,
  output logic            div_annul_o
);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_MACC     = 2'd1,
    S_DIV_WAIT = 2'd2,
    S_DIV_DONE = 2'd3
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [63:0] hilo_temp;

  logic        op_msub;
  logic        op_macc;
  logic        op_div;
  logic        div_by_zero;

  // Opcode classification; only consulted in S_IDLE, later cycles use latched data.
  always_comb begin
    op_msub     = (aluop_i == OP_MSUB) || (aluop_i == OP_MSUBU);
    op_macc     = op_msub || (aluop_i == OP_MADD) || (aluop_i == OP_MADDU);
    op_div      = (aluop_i == OP_DIV) || (aluop_i == OP_DIVU);
    div_by_zero = (reg2_i == 32'd0);
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode; annul always returns to idle, and wins over div_ready_i.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (!annul_i) begin
          if (op_macc) begin
            state_nxt = S_MACC;
          end else if (op_div && !div_by_zero) begin
            state_nxt = S_DIV_WAIT;
          end
        end
      end
      S_MACC: begin
        state_nxt = S_IDLE;
      end
      S_DIV_WAIT: begin
        if (annul_i) begin
          state_nxt = S_IDLE;
        end else if (div_ready_i) begin
          state_nxt = S_DIV_DONE;
        end
      end
      S_DIV_DONE: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // Combinational outputs: stall, HI/LO write-back and divider abort.
  // A divide by zero is resolved in S_IDLE without touching the divider.
  always_comb begin
    stallreq_o  = 1'b0;
    whilo_o     = 1'b0;
    hilo_o      = 64'd0;
    div_annul_o = 1'b0;
    case (state)
      S_IDLE: begin
        if (!annul_i) begin
          if (op_macc) begin
            stallreq_o = 1'b1;
          end else if (op_div) begin
            if (div_by_zero) begin
              whilo_o = 1'b1;
            end else begin
              stallreq_o = 1'b1;
            end
          end
        end
      end
      S_MACC: begin
        if (!annul_i) begin
          whilo_o = 1'b1;
          hilo_o  = hilo_temp + hilo_i;
        end
      end
      S_DIV_WAIT: begin
        if (annul_i) begin
          div_annul_o = 1'b1;
        end else begin
          stallreq_o = 1'b1;
        end
      end
      S_DIV_DONE: begin
        if (!annul_i) begin
          whilo_o = 1'b1;
          hilo_o  = hilo_temp;
        end
      end
      default: begin
        stallreq_o = 1'b0;
      end
    endcase
  end

  // Datapath registers: accumulator term, divider operands and the level-held start.
  // The divider operands stay put after the divide so the divider sees stable inputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      hilo_temp     <= 64'd0;
      div_start_o   <= 1'b0;
      div_signed_o  <= 1'b0;
      div_opdata1_o <= 32'd0;
      div_opdata2_o <= 32'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (!annul_i) begin
            if (op_macc) begin
              hilo_temp <= op_msub ? ((~mul_i) + 64'd1) : mul_i;
            end else if (op_div && !div_by_zero) begin
              div_opdata1_o <= reg1_i;
              div_opdata2_o <= reg2_i;
              div_signed_o  <= (aluop_i == OP_DIV);
              div_start_o   <= 1'b1;
            end
          end
        end
        S_DIV_WAIT: begin
          if (annul_i) begin
            div_start_o <= 1'b0;
          end else if (div_ready_i) begin
            hilo_temp   <= div_result_i;
            div_start_o <= 1'b0;
          end
        end
        default: begin
          div_start_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hilo_mc_ctrl.sv
// Bench for hilo_mc_ctrl: directed scenarios with literal expectations, then
// randomized traffic compared every cycle against a transaction-level model.
// Inputs change just after the falling edge; outputs are sampled 1 time unit
// later; the model advances on the rising edge.

module tb_hilo_mc_ctrl;

  localparam logic [7:0] OP_MADD  = 8'b10100110;
  localparam logic [7:0] OP_MADDU = 8'b10101000;
  localparam logic [7:0] OP_MSUB  = 8'b10101010;
  localparam logic [7:0] OP_MSUBU = 8'b10101011;
  localparam logic [7:0] OP_DIV   = 8'b00011010;
  localparam logic [7:0] OP_DIVU  = 8'b00011011;
  localparam logic [7:0] OP_NOP   = 8'h00;

  // model phases: nothing pending, accumulate write pending, divider busy, divide write pending
  localparam int M_FREE     = 0;
  localparam int M_ACC_WB   = 1;
  localparam int M_DIV_BUSY = 2;
  localparam int M_DIV_WB   = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  aluop_i;
  logic [31:0] reg1_i;
  logic [31:0] reg2_i;
  logic [63:0] mul_i;
  logic [63:0] hilo_i;
  logic        annul_i;
  logic [63:0] div_result_i;
  logic        div_ready_i;
  logic        stallreq_o;
  logic        whilo_o;
  logic [63:0] hilo_o;
  logic        div_start_o;
  logic        div_signed_o;
  logic [31:0] div_opdata1_o;
  logic [31:0] div_opdata2_o;
  logic        div_annul_o;

  always #5 clk = ~clk;

  hilo_mc_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .aluop_i      (aluop_i),
    .reg1_i       (reg1_i),
    .reg2_i       (reg2_i),
    .mul_i        (mul_i),
    .hilo_i       (hilo_i),
    .annul_i      (annul_i),
    .div_result_i (div_result_i),
    .div_ready_i  (div_ready_i),
    .stallreq_o   (stallreq_o),
    .whilo_o      (whilo_o),
    .hilo_o       (hilo_o),
    .div_start_o  (div_start_o),
    .div_signed_o (div_signed_o),
    .div_opdata1_o(div_opdata1_o),
    .div_opdata2_o(div_opdata2_o),
    .div_annul_o  (div_annul_o)
  );

  int total = 0;
  int bad   = 0;

  int          m_mode   = M_FREE;
  logic [63:0] m_temp   = 64'd0;
  logic        m_start  = 1'b0;
  logic        m_signed = 1'b0;
  logic [31:0] m_a      = 32'd0;
  logic [31:0] m_b      = 32'd0;
  int          m_cnt    = 0;
  int          dir_lat  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] div_ref(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    logic [31:0] uq, ur;
    if (b == 32'd0) return 64'd0;
    if (sgn) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      q  = sa / sb;
      r  = sa % sb;
      return {r[31:0], q[31:0]};
    end
    uq = a / b;
    ur = a % b;
    return {ur, uq};
  endfunction

  function automatic bit is_macc(input logic [7:0] op);
    return op == OP_MADD || op == OP_MADDU || op == OP_MSUB || op == OP_MSUBU;
  endfunction

  function automatic bit is_div(input logic [7:0] op);
    return op == OP_DIV || op == OP_DIVU;
  endfunction

  // The bench plays the divider: ready comes m_cnt cycles after start rises.
  task automatic set_div_inputs();
    div_ready_i  = (m_mode == M_DIV_BUSY) && (m_cnt == 1);
    div_result_i = div_ready_i ? div_ref(m_signed, m_a, m_b) : {$urandom, $urandom};
  endtask

  // Per-cycle compare of every output against the model.
  task automatic compare();
    logic        es, ew, ea;
    logic [63:0] eh;
    es = 1'b0; ew = 1'b0; ea = 1'b0; eh = 64'd0;
    if (m_mode == M_FREE) begin
      if (!annul_i && is_macc(aluop_i)) es = 1'b1;
      else if (!annul_i && is_div(aluop_i)) begin
        if (reg2_i == 32'd0) ew = 1'b1;
        else es = 1'b1;
      end
    end else if (m_mode == M_ACC_WB) begin
      if (!annul_i) begin ew = 1'b1; eh = m_temp + hilo_i; end
    end else if (m_mode == M_DIV_BUSY) begin
      if (annul_i) ea = 1'b1;
      else es = 1'b1;
    end else begin
      if (!annul_i) begin ew = 1'b1; eh = m_temp; end
    end
    chk("stallreq", 64'(stallreq_o), 64'(es));
    chk("whilo", 64'(whilo_o), 64'(ew));
    chk("hilo", hilo_o, eh);
    chk("div_annul", 64'(div_annul_o), 64'(ea));
    chk("div_start", 64'(div_start_o), 64'(m_start));
    chk("div_signed", 64'(div_signed_o), 64'(m_signed));
    chk("div_opdata1", 64'(div_opdata1_o), 64'(m_a));
    chk("div_opdata2", 64'(div_opdata2_o), 64'(m_b));
  endtask

  // Model advance at the rising edge, from the inputs held across it.
  task automatic model_step();
    if (!rst) begin
      m_mode = M_FREE; m_temp = 64'd0; m_start = 1'b0;
      m_signed = 1'b0; m_a = 32'd0; m_b = 32'd0; m_cnt = 0;
      return;
    end
    case (m_mode)
      M_FREE: begin
        if (!annul_i && is_macc(aluop_i)) begin
          m_temp = (aluop_i == OP_MSUB || aluop_i == OP_MSUBU) ? 64'd0 - mul_i : mul_i;
          m_mode = M_ACC_WB;
        end else if (!annul_i && is_div(aluop_i) && reg2_i != 32'd0) begin
          m_a = reg1_i; m_b = reg2_i; m_signed = (aluop_i == OP_DIV);
          m_start = 1'b1; m_mode = M_DIV_BUSY;
          m_cnt = (dir_lat != 0) ? dir_lat : int'($urandom_range(1, 4));
        end
      end
      M_DIV_BUSY: begin
        if (annul_i) begin
          m_start = 1'b0; m_mode = M_FREE;
        end else if (div_ready_i) begin
          m_temp = div_result_i; m_start = 1'b0; m_mode = M_DIV_WB;
        end else begin
          m_cnt--;
        end
      end
      default: m_mode = M_FREE;
    endcase
  endtask

  task automatic settle();
    set_div_inputs();
    #1;
    compare();
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  initial begin
    #1000000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b0; aluop_i = OP_NOP; reg1_i = 32'd0; reg2_i = 32'd0;
    mul_i = 64'd0; hilo_i = 64'd0; annul_i = 1'b0;
    div_result_i = 64'd0; div_ready_i = 1'b0;

    // reset
    @(negedge clk);
    tick();
    settle();
    chk("rst_stall", 64'(stallreq_o), 64'd0);
    chk("rst_start", 64'(div_start_o), 64'd0);
    chk("rst_hilo", hilo_o, 64'd0);
    chk("rst_opdata1", 64'(div_opdata1_o), 64'd0);
    tick();
    rst = 1'b1;

    // MADD
    aluop_i = OP_MADD; mul_i = 64'h6; hilo_i = 64'h0000_0001_0000_0002;
    settle();
    chk("madd_c0_stall", 64'(stallreq_o), 64'd1);
    chk("madd_c0_whilo", 64'(whilo_o), 64'd0);
    tick();
    aluop_i = OP_NOP;
    settle();
    chk("madd_c1_whilo", 64'(whilo_o), 64'd1);
    chk("madd_c1_hilo", hilo_o, 64'h0000_0001_0000_0008);
    chk("madd_c1_stall", 64'(stallreq_o), 64'd0);
    tick();

    // MSUB
    aluop_i = OP_MSUB; mul_i = 64'h3; hilo_i = 64'h1;
    settle();
    tick();
    aluop_i = OP_NOP;
    settle();
    chk("msub_c1_hilo", hilo_o, 64'hFFFF_FFFF_FFFF_FFFE);
    tick();

    // DIVU 100/7, ready three cycles after start; opcode changes must be ignored
    dir_lat = 3; aluop_i = OP_DIVU; reg1_i = 32'd100; reg2_i = 32'd7;
    settle();
    chk("divu_c0_stall", 64'(stallreq_o), 64'd1);
    chk("divu_c0_start", 64'(div_start_o), 64'd0);
    tick();
    dir_lat = 0; aluop_i = OP_MADD;
    for (int i = 0; i < 3; i++) begin
      settle();
      chk("divu_wait_start", 64'(div_start_o), 64'd1);
      chk("divu_wait_stall", 64'(stallreq_o), 64'd1);
      chk("divu_wait_op1", 64'(div_opdata1_o), 64'd100);
      chk("divu_wait_op2", 64'(div_opdata2_o), 64'd7);
      chk("divu_wait_signed", 64'(div_signed_o), 64'd0);
      chk("divu_wait_whilo", 64'(whilo_o), 64'd0);
      tick();
    end
    aluop_i = OP_NOP;
    settle();
    chk("divu_done_whilo", 64'(whilo_o), 64'd1);
    chk("divu_done_hilo", hilo_o, 64'h0000_0002_0000_000E);
    chk("divu_done_stall", 64'(stallreq_o), 64'd0);
    chk("divu_done_start", 64'(div_start_o), 64'd0);
    tick();

    // DIV by zero resolves in one cycle without the divider
    aluop_i = OP_DIV; reg1_i = 32'd55; reg2_i = 32'd0; hilo_i = 64'hDEAD_BEEF_0123_4567;
    settle();
    chk("dz_whilo", 64'(whilo_o), 64'd1);
    chk("dz_hilo", hilo_o, 64'd0);
    chk("dz_stall", 64'(stallreq_o), 64'd0);
    chk("dz_start", 64'(div_start_o), 64'd0);
    tick();
    aluop_i = OP_NOP;
    settle();
    chk("dz_next_start", 64'(div_start_o), 64'd0);
    tick();

    // DIV annulled in the same cycle the divider reports ready
    dir_lat = 2; aluop_i = OP_DIV; reg1_i = 32'hFFFF_FFEC; reg2_i = 32'd3;
    settle();
    tick();
    dir_lat = 0; aluop_i = OP_NOP;
    settle();
    chk("dann_w1_stall", 64'(stallreq_o), 64'd1);
    chk("dann_w1_signed", 64'(div_signed_o), 64'd1);
    tick();
    annul_i = 1'b1;
    settle();
    chk("dann_annul", 64'(div_annul_o), 64'd1);
    chk("dann_whilo", 64'(whilo_o), 64'd0);
    chk("dann_stall", 64'(stallreq_o), 64'd0);
    tick();
    annul_i = 1'b0;
    for (int i = 0; i < 2; i++) begin
      settle();
      chk("dann_after_start", 64'(div_start_o), 64'd0);
      chk("dann_after_whilo", 64'(whilo_o), 64'd0);
      chk("dann_after_stall", 64'(stallreq_o), 64'd0);
      tick();
    end

    // reset while the divider is busy, then a normal MADD
    dir_lat = 4; aluop_i = OP_DIVU; reg1_i = 32'd9; reg2_i = 32'd2;
    settle();
    tick();
    dir_lat = 0; aluop_i = OP_NOP;
    settle();
    chk("rstdiv_start_before", 64'(div_start_o), 64'd1);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    settle();
    chk("rstdiv_start_after", 64'(div_start_o), 64'd0);
    chk("rstdiv_stall_after", 64'(stallreq_o), 64'd0);
    tick();
    aluop_i = OP_MADDU; mul_i = 64'd5; hilo_i = 64'd10;
    settle();
    chk("rstdiv_madd_stall", 64'(stallreq_o), 64'd1);
    tick();
    aluop_i = OP_NOP;
    settle();
    chk("rstdiv_madd_hilo", hilo_o, 64'd15);
    chk("rstdiv_madd_whilo", 64'(whilo_o), 64'd1);
    tick();

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      int r;
      rst     = ($urandom_range(0, 79) != 0);
      annul_i = ($urandom_range(0, 7) == 0);
      r = int'($urandom_range(0, 9));
      case (r)
        0: aluop_i = OP_MADD;
        1: aluop_i = OP_MADDU;
        2: aluop_i = OP_MSUB;
        3: aluop_i = OP_MSUBU;
        4, 5: aluop_i = OP_DIV;
        6: aluop_i = OP_DIVU;
        default: aluop_i = 8'($urandom);
      endcase
      reg1_i = $urandom;
      reg2_i = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
      mul_i  = {$urandom, $urandom};
      hilo_i = {$urandom, $urandom};
      settle();
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
